oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
Owns the single sram port and shares it between the CPU datapath (memory address/data path) and an internal OAM DMA engine. A CPU write to the DMA register (0xFF46) starts a 160-byte copy from {src_hi,8'h00} into OAM at 0xFE00. While the copy runs, the block holds the bus and stalls the CPU. It sits between datapath and sram.

Parameters:
DMA_REG, 16'hFF46, CPU-visible DMA start/source register address
OAM_BASE, 16'hFE00, DMA destination base
DMA_LEN, 160, bytes per transfer (max 256)
ECHO_OFS, 8'h20, subtracted from src_hi when src_hi >= 8'hE0 (echo RAM)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
cpu_addr  in  16  CPU address (MAR)
cpu_wdata  in  8  CPU write data (MDR)
cpu_re  in  1  CPU read request
cpu_we  in  1  CPU write request
cpu_rdata  out  8  read data returned to CPU
cpu_stall  out  1  CPU access not serviced this cycle; CPU must hold request
mem_addr  out  16  sram address
mem_wdata  out  8  sram write data
mem_re  out  1  sram read enable
mem_we  out  1  sram write enable
mem_rdata  in  8  sram read data, valid in the same cycle mem_re is high
dma_active  out  1  DMA owns the bus
dma_src_hi  out  8  last value written to DMA_REG

Behaviour:
- Reset (rst=0, any time incl. mid-transfer): state IDLE, idx=0, src_hi=0, buf=0; outputs: cpu_stall=0, dma_active=0, mem_re=mem_we=0, mem_addr=cpu_addr, cpu_rdata=mem_rdata (pass-through). No partial OAM write after reset.
- States: IDLE, START, READ, WRITE.
- cpu_re and cpu_we both high: write wins, read ignored.
- DMA_REG decode (any state): cpu_we to DMA_REG -> src_hi<=cpu_wdata, not forwarded (mem_we=0), never stalled. cpu_re of DMA_REG -> cpu_rdata=src_hi, mem_re=0, never stalled.
- IDLE: combinational pass-through of addr/wdata/re/we; cpu_stall=0. DMA_REG write -> START.
- START (1 cycle): pass-through as IDLE, dma_active=0; next READ, idx=0.
- READ: mem_addr={eff_hi,idx}, eff_hi=src_hi-ECHO_OFS if src_hi>=8'hE0 else src_hi; mem_re=1; buf<=mem_rdata at edge; next WRITE.
- WRITE: mem_addr=OAM_BASE+idx, mem_wdata=buf, mem_we=1; if idx==DMA_LEN-1 -> IDLE, idx<=0; else idx<=idx+1, -> READ.
- READ/WRITE: dma_active=1; any CPU re/we not to DMA_REG -> cpu_stall=1, request not forwarded; cpu_rdata=8'h00 when stalled.
- Restart: DMA_REG write during READ/WRITE -> src_hi updated, current cycle's DMA access still completes, next state START, idx=0. Bytes already copied stay.
- Latency: DMA_REG write in cycle T -> START T+1 -> first READ T+2 -> last WRITE T+321 -> IDLE, dma_active=0 at T+322. 2 cycles/byte, 320 bus cycles total.
- idx 8 bits; OAM_BASE+idx computed 16-bit, no wrap for DMA_LEN<=256.

Decomposition:
- Shared constants package (constants.sv): dma_state_t enum {DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE}, DMA_REG_ADDR, OAM_BASE_ADDR, DMA_LEN default.
- Single module; counter, state register and bus mux inline. No sub-module warranted.

Test Plan:
- Reset mid-transfer: start DMA src 8'hC0, drop rst at byte 50 -> next cycle dma_active=0, mem_we=0, state IDLE; OAM 0xFE32.. unchanged.
- Full copy: preload 0xC000-0xC09F with i^8'h5A, write 8'hC0 to 0xFF46 at T -> dma_active rises T+2, falls T+322; OAM[i]==i^8'h5A for i=0..159, exactly 160 mem_we pulses.
- CPU stall: during DMA CPU reads 0xC010 -> cpu_stall=1 every cycle until T+322, then read serviced with correct data, no extra sram access.
- DMA_REG access: during DMA, CPU reads 0xFF46 -> cpu_rdata=8'hC0, cpu_stall=0, mem_re held by DMA only.
- Echo source: write 8'hE1 -> READ addresses 0xC100-0xC19F.
- Restart: rewrite 8'hD0 at byte 20 -> START next cycle, then copy restarts from 0xD000 to 0xFE00; final OAM equals 0xD000 block.

Source files
------------

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter.
// Contents: DMA state enum, bus request payload struct, address/length
// defaults and the echo-RAM source page helper.
package oam_dma_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 8;

  localparam logic [ADDR_W-1:0] DMA_REG_ADDR     = 16'hFF46;
  localparam logic [ADDR_W-1:0] OAM_BASE_ADDR    = 16'hFE00;
  localparam int unsigned       DMA_LEN_DEFAULT  = 160;
  localparam logic [DATA_W-1:0] ECHO_OFS_DEFAULT = 8'h20;
  localparam logic [DATA_W-1:0] ECHO_PAGE_MIN    = 8'hE0;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  // One sram access as driven onto the memory port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic              we;
  } mem_req_t;

  // Source pages at or above 0xE0 are echo RAM and alias down by ofs.
  function automatic logic [DATA_W-1:0] eff_src_hi(input logic [DATA_W-1:0] hi,
                                                   input logic [DATA_W-1:0] ofs);
    return (hi >= ECHO_PAGE_MIN) ? DATA_W'(hi - ofs) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and sram-side bus bundle around the OAM DMA arbiter.
// master: the arbiter (consumes CPU requests and sram read data,
//         drives CPU responses and the sram port).
// slave : the environment (datapath + sram).
interface oam_dma_arbiter_if;
  import oam_dma_arbiter_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_re;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_re, cpu_we, mem_rdata,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_re, cpu_we, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_re, mem_we
  );

endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the single sram port, passes CPU accesses through
// when idle and runs a DMA_LEN-byte copy from {src_hi,8'h00} into OAM
// after a write to DMA_REG, stalling CPU accesses while the copy runs.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   bus        - CPU request/response and sram port (master modport)
//   dma_active - DMA currently owns the sram port
//   dma_src_hi - last value written to DMA_REG
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG  = DMA_REG_ADDR,
  parameter logic [ADDR_W-1:0] OAM_BASE = OAM_BASE_ADDR,
  parameter int unsigned       DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [DATA_W-1:0] ECHO_OFS = ECHO_OFS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  oam_dma_arbiter_if.master   bus,
  output logic                dma_active,
  output logic [DATA_W-1:0]   dma_src_hi
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  dma_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] src_hi;
  logic [DATA_W-1:0] dma_buf, dma_buf_nxt;

  logic              cpu_rd;
  logic              reg_hit;
  logic              reg_wr;
  logic              reg_rd;
  logic              cpu_req;
  mem_req_t          req;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              active;

  // State, byte index, source page and staging byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DMA_IDLE;
      idx     <= '0;
      src_hi  <= '0;
      dma_buf <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dma_buf <= dma_buf_nxt;
      if (reg_wr) src_hi <= bus.cpu_wdata;
    end
  end

  // Next state, DMA_REG decode and sram port mux.
  always_comb begin
    // Simultaneous read and write: the write wins.
    cpu_rd  = bus.cpu_re & ~bus.cpu_we;
    reg_hit = (bus.cpu_addr == DMA_REG);
    reg_wr  = bus.cpu_we & reg_hit;
    reg_rd  = cpu_rd & reg_hit;
    cpu_req = (bus.cpu_we | cpu_rd) & ~reg_hit;

    state_nxt   = state;
    idx_nxt     = idx;
    dma_buf_nxt = dma_buf;
    req.addr    = bus.cpu_addr;
    req.wdata   = bus.cpu_wdata;
    req.re      = cpu_rd & ~reg_hit;
    req.we      = bus.cpu_we & ~reg_hit;
    rdata       = bus.mem_rdata;
    stall       = 1'b0;
    active      = 1'b0;

    case (state)
      DMA_IDLE: ;
      DMA_START: begin
        state_nxt = DMA_READ;
        idx_nxt   = '0;
      end
      DMA_READ: begin
        active      = 1'b1;
        stall       = cpu_req;
        req.addr    = {eff_src_hi(src_hi, ECHO_OFS), idx};
        req.wdata   = '0;
        req.re      = 1'b1;
        req.we      = 1'b0;
        dma_buf_nxt = bus.mem_rdata;
        state_nxt   = DMA_WRITE;
      end
      DMA_WRITE: begin
        active    = 1'b1;
        stall     = cpu_req;
        req.addr  = OAM_BASE + ADDR_W'(idx);
        req.wdata = dma_buf;
        req.re    = 1'b0;
        req.we    = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DMA_IDLE;
          idx_nxt   = '0;
        end else begin
          state_nxt = DMA_READ;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      default: state_nxt = DMA_IDLE;
    endcase

    // A DMA_REG write from any state (re)starts the copy; the current
    // cycle's DMA access above still goes out on the port.
    if (reg_wr) begin
      state_nxt = DMA_START;
      idx_nxt   = '0;
    end

    if (stall)  rdata = '0;
    if (reg_rd) rdata = src_hi;

    // Keep the sram quiet while reset is held.
    if (!rst) begin
      req.re = 1'b0;
      req.we = 1'b0;
    end
  end

  assign bus.mem_addr  = req.addr;
  assign bus.mem_wdata = req.wdata;
  assign bus.mem_re    = req.re;
  assign bus.mem_we    = req.we;
  assign bus.cpu_rdata = rdata;
  assign bus.cpu_stall = stall;
  assign dma_active    = active;
  assign dma_src_hi    = src_hi;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter with a behavioural sram.
module tb_oam_dma_arbiter;

  logic       clk;
  logic       rst;
  logic       dma_active;
  logic [7:0] dma_src_hi;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dma_active (dma_active),
    .dma_src_hi (dma_src_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded source blocks are a fixed function of address.
  function automatic logic [7:0] pat(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a[15:8])
      8'hC0:   return lo ^ 8'h5A;
      8'hC1:   return lo + 8'h03;
      8'hD0:   return lo * 8'd3 + 8'd1;
      default: return 8'hA7;
    endcase
  endfunction

  function automatic logic in_block(input logic [15:0] a);
    if (a == 16'h1234) return 1'b1;
    return (a[15:8] == 8'hC0 || a[15:8] == 8'hC1 || a[15:8] == 8'hD0) && (a[7:0] < 8'd160);
  endfunction

  logic [7:0] sram [65536];
  int         we_cnt = 0;

  always_comb begin
    if (in_block(bus.mem_addr)) bus.mem_rdata = pat(bus.mem_addr);
    else                        bus.mem_rdata = sram[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    bus.cpu_re    = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = a;
    bus.cpu_wdata = 8'h00;
  endtask

  // Runs until dma_active drops; n = DMA-active cycles seen, bad = reads off-page.
  task automatic run_to_idle(input logic [7:0] page, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (dma_active === 1'b1 && n < 400) begin
      if (bus.mem_re === 1'b1 && bus.mem_addr[15:8] !== page) bad++;
      n++;
      @(negedge clk); #1;
    end
  endtask

  function automatic int oam_bad(input logic [7:0] lo_page, input logic [7:0] hi_page,
                                 input int split);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (sram[16'hFE00 + 16'(i)] !== pat({(i < split) ? lo_page : hi_page, 8'(i)})) bad++;
    end
    return bad;
  endfunction

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int         n;
  int         bad;
  int         base;
  logic [15:0] last_addr;

  initial begin
    rst = 1'b0;
    cpu_read(16'h1234);
    @(negedge clk); #1;
    chk("rst_dma_active", 16'(dma_active), 16'h0);
    chk("rst_stall", 16'(bus.cpu_stall), 16'h0);
    chk("rst_mem_re", 16'(bus.mem_re), 16'h0);
    chk("rst_mem_we", 16'(bus.mem_we), 16'h0);
    chk("rst_mem_addr", bus.mem_addr, 16'h1234);
    chk("rst_rdata_pass", 16'(bus.cpu_rdata), 16'h00A7);
    chk("rst_src_hi", 16'(dma_src_hi), 16'h0000);

    @(negedge clk); rst = 1'b1; #1;
    chk("idle_read_fwd", 16'(bus.mem_re), 16'h1);

    // Read and write together: write wins.
    @(negedge clk);
    cpu_write(16'hC200, 8'h33); bus.cpu_re = 1'b1; #1;
    chk("rw_mem_we", 16'(bus.mem_we), 16'h1);
    chk("rw_mem_re", 16'(bus.mem_re), 16'h0);
    chk("rw_mem_addr", bus.mem_addr, 16'hC200);
    chk("rw_mem_wdata", 16'(bus.mem_wdata), 16'h0033);
    @(negedge clk); cpu_idle(); #1;
    chk("rw_sram_written", 16'(sram[16'hC200]), 16'h0033);

    // Full copy from 0xC000 with CPU accesses during the transfer.
    base = we_cnt;
    @(negedge clk); cpu_write(16'hFF46, 8'hC0); #1;            // T
    chk("start_reg_not_fwd", 16'(bus.mem_we), 16'h0);
    chk("start_reg_no_stall", 16'(bus.cpu_stall), 16'h0);
    @(negedge clk); cpu_idle(); #1;                              // T+1
    chk("start_inactive", 16'(dma_active), 16'h0);
    chk("start_src_hi", 16'(dma_src_hi), 16'h00C0);
    @(negedge clk); #1;                                          // T+2
    chk("rd0_active", 16'(dma_active), 16'h1);
    chk("rd0_mem_re", 16'(bus.mem_re), 16'h1);
    chk("rd0_addr", bus.mem_addr, 16'hC000);
    @(negedge clk); #1;                                          // T+3
    chk("wr0_mem_we", 16'(bus.mem_we), 16'h1);
    chk("wr0_addr", bus.mem_addr, 16'hFE00);
    chk("wr0_wdata", 16'(bus.mem_wdata), 16'h005A);
    @(negedge clk); cpu_read(16'hFF46); #1;                      // T+4
    chk("regrd_data", 16'(bus.cpu_rdata), 16'h00C0);
    chk("regrd_no_stall", 16'(bus.cpu_stall), 16'h0);
    chk("regrd_dma_addr", bus.mem_addr, 16'hC001);
    chk("regrd_dma_re", 16'(bus.mem_re), 16'h1);
    @(negedge clk); cpu_read(16'hC010); #1;                      // T+5
    chk("stall_rdata_zero", 16'(bus.cpu_rdata), 16'h0000);
    chk("stall_dma_addr", bus.mem_addr, 16'hFE01);
    n = 0;
    last_addr = 16'h0000;
    while (bus.cpu_stall === 1'b1 && n < 400) begin
      last_addr = bus.mem_addr;
      n++;
      @(negedge clk); #1;
    end
    chk("stall_cycles", 16'(n), 16'd317);
    chk("last_write_addr", last_addr, 16'hFE9F);
    chk("done_inactive", 16'(dma_active), 16'h0);              // T+322
    chk("svc_rdata", 16'(bus.cpu_rdata), 16'h004A);
    chk("svc_mem_re", 16'(bus.mem_re), 16'h1);
    chk("svc_addr", bus.mem_addr, 16'hC010);
    @(negedge clk); cpu_idle(); #1;
    chk("svc_no_extra_re", 16'(bus.mem_re), 16'h0);
    chk("full_we_pulses", 16'(we_cnt - base), 16'd160);
    chk("full_oam_data", 16'(oam_bad(8'hC0, 8'hC0, 160)), 16'd0);

    // Echo source page 0xE1 reads from 0xC1xx.
    @(negedge clk); cpu_write(16'hFF46, 8'hE1); #1;
    chk("echo_reg_not_fwd", 16'(bus.mem_we), 16'h0);
    @(negedge clk); cpu_idle(); #1;
    @(negedge clk); #1;
    chk("echo_rd0_addr", bus.mem_addr, 16'hC100);
    run_to_idle(8'hC1, n, bad);
    chk("echo_active_cycles", 16'(n), 16'd320);
    chk("echo_read_page", 16'(bad), 16'd0);
    chk("echo_oam_data", 16'(oam_bad(8'hC1, 8'hC1, 160)), 16'd0);

    // Restart with 0xD0 at the READ of byte 20.
    @(negedge clk); cpu_write(16'hFF46, 8'hC0); #1;
    @(negedge clk); cpu_idle();
    for (int i = 0; i < 41; i++) @(negedge clk);
    cpu_write(16'hFF46, 8'hD0); #1;
    chk("rs_cur_read_done", 16'(bus.mem_re), 16'h1);
    chk("rs_cur_addr", bus.mem_addr, 16'hC014);
    chk("rs_no_stall", 16'(bus.cpu_stall), 16'h0);
    @(negedge clk); cpu_idle(); #1;
    chk("rs_start", 16'(dma_active), 16'h0);
    chk("rs_src_hi", 16'(dma_src_hi), 16'h00D0);
    @(negedge clk); #1;
    chk("rs_rd0_addr", bus.mem_addr, 16'hD000);
    run_to_idle(8'hD0, n, bad);
    chk("rs_active_cycles", 16'(n), 16'd320);
    chk("rs_read_page", 16'(bad), 16'd0);
    chk("rs_oam_data", 16'(oam_bad(8'hD0, 8'hD0, 160)), 16'd0);

    // Reset at the READ of byte 50.
    @(negedge clk); cpu_write(16'hFF46, 8'hC0); #1;
    @(negedge clk); cpu_idle();
    for (int i = 0; i < 101; i++) @(negedge clk);
    #1;
    chk("mr_pre_addr", bus.mem_addr, 16'hC032);
    rst = 1'b0; #1;
    chk("mr_inactive", 16'(dma_active), 16'h0);
    chk("mr_mem_we", 16'(bus.mem_we), 16'h0);
    chk("mr_mem_re", 16'(bus.mem_re), 16'h0);
    @(negedge clk); #1;
    chk("mr_next_inactive", 16'(dma_active), 16'h0);
    chk("mr_next_mem_we", 16'(bus.mem_we), 16'h0);
    chk("mr_src_hi", 16'(dma_src_hi), 16'h0000);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("mr_idle_after", 16'(dma_active), 16'h0);
    chk("mr_oam_data", 16'(oam_bad(8'hC0, 8'hD0, 50)), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
